// File: rtl/tx_symbol_scheduler.sv
// tx_symbol_scheduler: round-robin word arbiter, baud strobe generator and
// symbol framer feeding a 3-bit parallel-load transmit shift register.
// Each accepted word goes out as START_SYM followed by its 3-bit chunks,
// LSB chunk first; a symbol advances only when the shift register consumes it.
module tx_symbol_scheduler #(
  parameter int           WORD_W    = 8,
  parameter int           BAUD_DIV  = 4,
  parameter logic [2:0]   START_SYM = 3'b101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [2:0]        tx_symbol,
  output logic              tx_shift,
  input  logic              tx_request,
  output logic              busy,
  output logic              grant_id
);

  localparam int NCHUNK = (WORD_W + 2) / 3;
  localparam int PADW   = NCHUNK * 3;
  localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BCNT_W = $clog2(BAUD_DIV);
  localparam logic [BCNT_W-1:0] BAUD_LAST = BCNT_W'(BAUD_DIV - 1);
  localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t              r_state;
  logic [BCNT_W-1:0]   r_baud_cnt;
  logic [CIDX_W-1:0]   r_chunk_idx;
  logic [WORD_W-1:0]   r_word;
  logic                r_last_grant;
  logic                r_grant_id;

  logic                w_consume;
  logic                w_grant_any;
  logic                w_grant_src;
  logic [WORD_W-1:0]   w_grant_data;
  logic [PADW-1:0]     w_word_pad;
  logic [2:0]          w_chunk;

  // Free-running baud counter; it never stalls, so strobes stay periodic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
    end else if (r_baud_cnt == BAUD_LAST) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  assign tx_shift  = (r_baud_cnt == BAUD_LAST);
  // A request outside a strobe is a protocol violation and is ignored.
  assign w_consume = tx_request & tx_shift;

  // Zero-extend the held word to a whole number of 3-bit chunks.
  always_comb begin
    w_word_pad                = '0;
    w_word_pad[WORD_W-1:0]    = r_word;
  end

  // Select the chunk addressed by chunk_idx.
  always_comb begin
    w_chunk = 3'b000;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_chunk_idx == CIDX_W'(k)) begin
        w_chunk = w_word_pad[3*k +: 3];
      end else begin
        w_chunk = w_chunk;
      end
    end
  end

  // Symbol presented to the shift register depends only on registered state.
  always_comb begin
    case (r_state)
      S_IDLE:  tx_symbol = 3'b000;
      S_START: tx_symbol = START_SYM;
      S_DATA:  tx_symbol = w_chunk;
      default: tx_symbol = 3'b000;
    endcase
  end

  // Round-robin arbitration: on contention favour the source not served last.
  always_comb begin
    w_grant_any = (r_state == S_IDLE) & (req0_valid | req1_valid);
    if (req0_valid & req1_valid) begin
      w_grant_src = ~r_last_grant;
    end else begin
      w_grant_src = req1_valid;
    end
    if (w_grant_src) begin
      w_grant_data = req1_data;
    end else begin
      w_grant_data = req0_data;
    end
  end

  assign req0_ready = w_grant_any & ~w_grant_src;
  assign req1_ready = w_grant_any &  w_grant_src;
  assign busy       = (r_state != S_IDLE);
  assign grant_id   = r_grant_id;

  // Framing FSM: accept a word in IDLE, then walk START and DATA chunks,
  // advancing one symbol per consumed strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_chunk_idx  <= '0;
      r_word       <= '0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_word       <= w_grant_data;
            r_last_grant <= w_grant_src;
            r_grant_id   <= w_grant_src;
            r_state      <= S_START;
          end else begin
            r_state      <= S_IDLE;
          end
        end
        S_START: begin
          if (w_consume) begin
            r_chunk_idx <= '0;
            r_state     <= S_DATA;
          end else begin
            r_state     <= S_START;
          end
        end
        S_DATA: begin
          if (w_consume) begin
            if (r_chunk_idx == CIDX_LAST) begin
              r_chunk_idx <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_chunk_idx <= r_chunk_idx + 1'b1;
            end
          end else begin
            r_state <= S_DATA;
          end
        end
        default: begin
          r_chunk_idx <= '0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed bench for tx_symbol_scheduler: WORD_W=8 main instance plus
// WORD_W=9 and WORD_W=4 instances for chunk padding.
module tb_tx_symbol_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         sel = 0;
  logic       treq = 1'b0;

  // WORD_W=8 instance signals
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       r0, r1, shift8, busy8, gid8;
  logic [2:0] sym8;
  // WORD_W=9 instance signals
  logic       v9 = 1'b0;
  logic [8:0] d9 = 9'h000;
  logic       r9, r9b, shift9, busy9, gid9;
  logic [2:0] sym9;
  // WORD_W=4 instance signals
  logic       v4 = 1'b0;
  logic [3:0] d4 = 4'h0;
  logic       r4, r4b, shift4, busy4, gid4;
  logic [2:0] sym4;

  logic       w_shift;
  logic [2:0] w_sym;

  always #5 clk = ~clk;

  tx_symbol_scheduler #(.WORD_W(8), .BAUD_DIV(4), .START_SYM(3'b101)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .tx_symbol(sym8), .tx_shift(shift8), .tx_request(treq && (sel == 0)),
    .busy(busy8), .grant_id(gid8)
  );

  tx_symbol_scheduler #(.WORD_W(9), .BAUD_DIV(4), .START_SYM(3'b101)) u_dut9 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v9), .req0_data(d9), .req0_ready(r9),
    .req1_valid(1'b0), .req1_data(9'h000), .req1_ready(r9b),
    .tx_symbol(sym9), .tx_shift(shift9), .tx_request(treq && (sel == 1)),
    .busy(busy9), .grant_id(gid9)
  );

  tx_symbol_scheduler #(.WORD_W(4), .BAUD_DIV(4), .START_SYM(3'b101)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v4), .req0_data(d4), .req0_ready(r4),
    .req1_valid(1'b0), .req1_data(4'h0), .req1_ready(r4b),
    .tx_symbol(sym4), .tx_shift(shift4), .tx_request(treq && (sel == 2)),
    .busy(busy4), .grant_id(gid4)
  );

  always_comb begin
    case (sel)
      1:       begin w_shift = shift9; w_sym = sym9; end
      2:       begin w_shift = shift4; w_sym = sym4; end
      default: begin w_shift = shift8; w_sym = sym8; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge where the selected instance strobes.
  task automatic wait_strobe();
    int n;
    n = 0;
    @(negedge clk);
    while (!w_shift && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("strobe_seen", 32'(w_shift), 32'd1);
  endtask

  // Consume one symbol on the next strobe after checking it.
  task automatic consume(input string tag, input logic [2:0] exp);
    wait_strobe();
    check(tag, 32'(w_sym), 32'(exp));
    treq = 1'b1;
    @(negedge clk);
    treq = 1'b0;
  endtask

  // Let two strobes pass unconsumed, then consume on the third.
  task automatic consume3(input string tag, input logic [2:0] exp);
    for (int s = 0; s < 3; s++) begin
      wait_strobe();
      check(tag, 32'(w_sym), 32'(exp));
    end
    treq = 1'b1;
    @(negedge clk);
    treq = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one word on the WORD_W=8 instance and drop valid once accepted.
  task automatic send_word(input logic src, input logic [7:0] d);
    if (src) begin v1 = 1'b1; d1 = d; end
    else begin v0 = 1'b1; d0 = d; end
    #1;
    check("ready0_on_grant", 32'(r0), 32'(!src));
    check("ready1_on_grant", 32'(r1), 32'(src));
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
    check("busy_after_grant", 32'(busy8), 32'd1);
    check("grant_id", 32'(gid8), 32'(src));
    check("ready_gone_in_start", 32'({r0, r1}), 32'd0);
    check("start_symbol", 32'(sym8), 32'd5);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_symbol", 32'(sym8), 32'd0);
    check("rst_shift", 32'(shift8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_ready", 32'({r0, r1}), 32'd0);
    check("rst_grant_id", 32'(gid8), 32'd0);
    rst_n = 1'b1;
    // Idle strobe cadence: high after cycles 3, 7, 11
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("idle_shift", 32'(shift8), 32'((c % 4) == 3));
      check("idle_symbol", 32'(sym8), 32'd0);
      check("idle_busy_ready", 32'({busy8, r0, r1}), 32'd0);
    end

    // Single word B5 -> 101, 101, 110, 010
    send_word(1'b0, 8'hB5);
    consume("b5_start", 3'b101);
    consume("b5_c0", 3'b101);
    consume("b5_c1", 3'b110);
    consume("b5_c2", 3'b010);
    check("b5_done_busy", 32'(busy8), 32'd0);
    check("b5_done_symbol", 32'(sym8), 32'd0);

    // Both valid from reset: source 0 first, then 1, then 0 again
    do_reset();
    v0 = 1'b1; d0 = 8'h01; v1 = 1'b1; d1 = 8'h02;
    #1;
    check("both_first_ready0", 32'(r0), 32'd1);
    check("both_first_ready1", 32'(r1), 32'd0);
    @(negedge clk);
    check("both_first_gid", 32'(gid8), 32'd0);
    consume("w01_start", 3'b101);
    consume("w01_c0", 3'b001);
    consume("w01_c1", 3'b000);
    consume("w01_c2", 3'b000);
    check("both_second_ready1", 32'(r1), 32'd1);
    check("both_second_ready0", 32'(r0), 32'd0);
    @(negedge clk);
    check("both_second_gid", 32'(gid8), 32'd1);
    check("both_second_busy", 32'(busy8), 32'd1);
    consume("w02_start", 3'b101);
    consume("w02_c0", 3'b010);
    consume("w02_c1", 3'b000);
    consume("w02_c2", 3'b000);
    check("both_third_ready0", 32'(r0), 32'd1);
    check("both_third_ready1", 32'(r1), 32'd0);
    v0 = 1'b0;
    v1 = 1'b0;
    @(negedge clk);
    check("both_end_busy", 32'(busy8), 32'd0);

    // Slow consumer: request only on every third strobe
    send_word(1'b1, 8'h5C);
    consume3("slow_start", 3'b101);
    consume3("slow_c0", 3'b100);
    consume3("slow_c1", 3'b011);
    consume3("slow_c2", 3'b001);
    check("slow_done_busy", 32'(busy8), 32'd0);

    // Reset in DATA with chunk_idx=1
    send_word(1'b0, 8'hB5);
    consume("mid_start", 3'b101);
    consume("mid_c0", 3'b101);
    check("mid_in_data", 32'(sym8), 32'b110);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_symbol", 32'(sym8), 32'd0);
    check("mid_rst_shift", 32'(shift8), 32'd0);
    check("mid_rst_ready", 32'({r0, r1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_after_busy", 32'(busy8), 32'd0);
    send_word(1'b0, 8'h3A);
    // Request outside a strobe must be ignored
    begin
      int n;
      n = 0;
      while (shift8 && n < 4) begin
        @(negedge clk);
        n++;
      end
      check("violation_shift_low", 32'(shift8), 32'd0);
    end
    treq = 1'b1;
    @(negedge clk);
    treq = 1'b0;
    check("violation_ignored", 32'(sym8), 32'b101);
    consume("w3a_start", 3'b101);
    consume("w3a_c0", 3'b010);
    consume("w3a_c1", 3'b111);
    consume("w3a_c2", 3'b000);
    check("w3a_done_busy", 32'(busy8), 32'd0);

    // WORD_W=9, word 1FF -> 111, 111, 111
    sel = 1;
    v9 = 1'b1; d9 = 9'h1FF;
    #1;
    check("w9_ready", 32'(r9), 32'd1);
    @(negedge clk);
    v9 = 1'b0;
    consume("w9_start", 3'b101);
    consume("w9_c0", 3'b111);
    consume("w9_c1", 3'b111);
    consume("w9_c2", 3'b111);
    check("w9_done_busy", 32'(busy9), 32'd0);

    // WORD_W=4, word A -> 010, 001
    sel = 2;
    v4 = 1'b1; d4 = 4'hA;
    #1;
    check("w4_ready", 32'(r4), 32'd1);
    @(negedge clk);
    v4 = 1'b0;
    consume("w4_start", 3'b101);
    consume("w4_c0", 3'b010);
    consume("w4_c1", 3'b001);
    check("w4_done_busy", 32'(busy4), 32'd0);
    check("w4_done_symbol", 32'(sym4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
